// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one 16-bit word at the sampled PC, hands it to the decoder
// with PC+2, and reports misaligned PCs or memory timeouts as a sticky fetch fault.
module fetch_unit #(
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [15:0] RESET_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic [15:0] pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] instr,
  output logic [15:0] pc_next,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic [7:0]  cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      cnt         <= '0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      instr       <= RESET_INSTR;
      pc_next     <= '0;
      fetch_done  <= 1'b0;
      fetch_fault <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (fetch_en) begin
            addr_q      <= pc;
            fetch_done  <= 1'b0;
            fetch_fault <= 1'b0;
            if (pc[0]) begin
              state       <= S_FAULT;
              fetch_fault <= 1'b1;
              instr       <= RESET_INSTR;
            end else begin
              state <= S_REQ;
              busy  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          mem_addr <= addr_q;
          mem_rd   <= 1'b1;
          cnt      <= 8'(TIMEOUT);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // An ack on the same edge the counter expires takes priority over the timeout.
          if (mem_ack) begin
            instr      <= mem_rdata;
            pc_next    <= addr_q + 16'd2;
            fetch_done <= 1'b1;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else if (cnt == '0) begin
            fetch_fault <= 1'b1;
            instr       <= RESET_INSTR;
            mem_rd      <= 1'b0;
            busy        <= 1'b0;
            state       <= S_FAULT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected responses, a negedge monitor
// pops them whenever fetch_done or fetch_fault rises.
module tb_fetch_unit;

  localparam int unsigned T  = 4;
  localparam logic [15:0] RI = 16'hBEEF;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [15:0] pc;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] instr;
  logic [15:0] pc_next;
  logic        fetch_done;
  logic        fetch_fault;
  logic        busy;

  fetch_unit #(.TIMEOUT(T), .RESET_INSTR(RI)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .pc_next(pc_next), .fetch_done(fetch_done),
    .fetch_fault(fetch_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [15:0] instr;
    logic [15:0] pc_next;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each completion/fault against the head of the scoreboard.
  logic pd = 1'b0;
  logic pf = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (fetch_done && !pd) begin
      if (sbq.size() == 0) check("unexpected_done", 16'd1, 16'd0);
      else begin
        e = sbq.pop_front();
        check("resp_kind_done", 16'd0, 16'(e.is_fault));
        check("instr", instr, e.instr);
        check("pc_next", pc_next, e.pc_next);
      end
    end
    if (fetch_fault && !pf) begin
      if (sbq.size() == 0) check("unexpected_fault", 16'd1, 16'd0);
      else begin
        e = sbq.pop_front();
        check("resp_kind_fault", 16'd1, 16'(e.is_fault));
        check("fault_instr", instr, e.instr);
      end
    end
    pd = fetch_done;
    pf = fetch_fault;
  end

  // One fetch transaction. lat = cycles after E1 at which ack is sampled (lat > T+1 is a late ack).
  task automatic fetch(input logic [15:0] p, input int lat, input logic [15:0] data, input bit poke);
    exp_t e;
    bit   mis;
    bit   ok;
    int   last;
    mis        = p[0];
    ok         = !mis && lat >= 1 && lat <= int'(T) + 1;
    e.is_fault = !ok;
    e.instr    = ok ? data : RI;
    e.pc_next  = p + 16'd2;
    sbq.push_back(e);

    pc       = p;
    fetch_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_en = 1'b0;
    pc       = 16'($urandom);
    check("done_clr_on_accept", 16'(fetch_done), 16'd0);
    check("fault_on_accept", 16'(fetch_fault), 16'(mis));
    if (mis) begin
      repeat (3) begin
        @(negedge clk);
        check("mis_no_rd", 16'(mem_rd), 16'd0);
        check("mis_busy", 16'(busy), 16'd0);
      end
      return;
    end
    check("busy_after_accept", 16'(busy), 16'd1);
    @(negedge clk);
    check("rd_after_E1", 16'(mem_rd), 16'd1);
    check("addr_after_E1", mem_addr, p);

    last = (lat > int'(T) + 1 ? lat : int'(T) + 1);
    if (ok) last = lat;
    last = last + 1;
    for (int k = 1; k <= last; k++) begin
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? data : 16'($urandom);
      if (poke) begin
        fetch_en = (k == 1);
        pc       = p ^ 16'h0100;
      end
      @(negedge clk);
      if (ok) begin
        check("done_timing", 16'(fetch_done), 16'(k >= lat));
        check("rd_hold", 16'(mem_rd), 16'(k < lat));
        check("busy_hold", 16'(busy), 16'(k < lat));
        if (k < lat) check("addr_stable", mem_addr, p);
      end else begin
        check("to_fault_timing", 16'(fetch_fault), 16'(k >= int'(T) + 1));
        check("to_no_done", 16'(fetch_done), 16'd0);
        check("to_rd", 16'(mem_rd), 16'(k < int'(T) + 1));
      end
    end
    mem_ack  = 1'b0;
    fetch_en = 1'b0;
  endtask

  initial begin
    bit          prev_fault;
    logic [15:0] p;
    int          lat;

    reset     = 1'b0;
    fetch_en  = 1'b0;
    pc        = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_rd", 16'(mem_rd), 16'd0);
    check("rst_instr", instr, RI);
    check("rst_pc_next", pc_next, 16'h0000);
    check("rst_done", 16'(fetch_done), 16'd0);
    check("rst_fault", 16'(fetch_fault), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    reset = 1'b1;
    @(negedge clk);

    fetch(16'h0010, 2, 16'hA5C3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("done_held", 16'(fetch_done), 16'd1);
      check("instr_held", instr, 16'hA5C3);
      check("pc_next_held", pc_next, 16'h0012);
    end
    fetch(16'h0012, 2, 16'h1111, 1'b0);
    fetch(16'h0014, 1, 16'h2222, 1'b0);
    fetch(16'h0013, 2, 16'h0000, 1'b0);
    fetch(16'h0014, 3, 16'h3333, 1'b0);
    fetch(16'h0040, 7, 16'h4444, 1'b0);
    fetch(16'h0042, int'(T) + 1, 16'h5555, 1'b0);
    fetch(16'hFFFE, 2, 16'h1234, 1'b1);

    pc       = 16'h0030;
    fetch_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    check("rd_before_reset", 16'(mem_rd), 16'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_rd", 16'(mem_rd), 16'd0);
    check("async_rst_busy", 16'(busy), 16'd0);
    check("async_rst_done", 16'(fetch_done), 16'd0);
    check("async_rst_instr", instr, RI);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fetch(16'h0020, 2, 16'h6789, 1'b0);

    prev_fault = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p   = 16'($urandom);
      lat = $urandom_range(1, 7);
      if (prev_fault || $urandom_range(0, 4) != 0) p[0] = 1'b0;
      else p[0] = 1'b1;
      fetch(p, lat, 16'($urandom), 1'($urandom_range(0, 1)));
      prev_fault = p[0] || lat > int'(T) + 1;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 16'(sbq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
